// File: rtl/game_2048_pkg.sv
// Shared 2048 definitions: directions, tile codes, board width, FSM states.
// Used by the move engine and the win/lose status checker.
package game_2048_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_WIN   = 4'd11;
    localparam logic [3:0] TILE_MAX   = 4'd15;

    localparam int unsigned BOARD_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StSpawn,
        StDone
    } state_t;

    // Cell index of element j of line k; element 0 sits against the destination wall.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] k,
                                            input logic [1:0] j);
        logic [3:0] idx;
        case (dir)
            DIR_UP:   idx = {j, k};
            DIR_DOWN: idx = {~j, k};
            DIR_LEFT: idx = {k, j};
            default:  idx = {k, ~j};
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/game_2048_line_merge.sv
// Combinational slide/merge of one 4-tile line toward element 0.
// GAME_2048_SCORE_EN adds the merge-score output.
module game_2048_line_merge
    import game_2048_pkg::*;
(
    input  logic [15:0] i_line,
    output logic [15:0] o_line,
`ifdef GAME_2048_SCORE_EN
    output logic [16:0] o_score,
`endif
    output logic        o_changed
);

    logic [3:0] w_comp [8];
    logic [2:0] w_n;
    logic [2:0] w_o;
    logic       w_skip;
    logic [16:0] w_score;

    always_comb begin
        w_comp  = '{default: '0};
        w_n     = '0;
        w_o     = '0;
        w_skip  = 1'b0;
        w_score = '0;
        o_line  = '0;
        for (int j = 0; j < 4; j++) begin
            if (i_line[j*4 +: 4] != TILE_EMPTY) begin
                w_comp[w_n] = i_line[j*4 +: 4];
                w_n         = w_n + 3'd1;
            end
        end
        // A merged pair consumes two compacted tiles, so its partner is skipped.
        for (int j = 0; j < 4; j++) begin
            if (w_skip) begin
                w_skip = 1'b0;
            end else if (w_comp[j] != TILE_EMPTY) begin
                if (w_comp[j] == w_comp[j+1] && w_comp[j] != TILE_MAX) begin
                    o_line[{w_o[1:0], 2'b00} +: 4] = w_comp[j] + 4'd1;
                    w_score = w_score + (17'd1 << ({1'b0, w_comp[j]} + 5'd1));
                    w_skip  = 1'b1;
                end else begin
                    o_line[{w_o[1:0], 2'b00} +: 4] = w_comp[j];
                end
                w_o = w_o + 3'd1;
            end
        end
        o_changed = (o_line != i_line);
    end

`ifdef GAME_2048_SCORE_EN
    assign o_score = w_score;
`endif

endmodule

// File: rtl/game_2048_move_engine.sv
// 2048 board owner: one slide/merge line per cycle, random spawn, then commit.
// GAME_2048_SCORE_EN adds the o_score accumulator.
module game_2048_move_engine
    import game_2048_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [3:0]  FOUR_ODDS = 4'd0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_move_valid,
    input  logic [1:0]           i_move_dir,
    output logic                 o_move_ready,
    input  logic                 i_lock,
    input  logic                 i_new_game,
    input  logic                 i_load_valid,
    input  logic [BOARD_W-1:0]   i_load_board,
    output logic [BOARD_W-1:0]   o_board_state,
`ifdef GAME_2048_SCORE_EN
    output logic [31:0]          o_score,
`endif
    output logic                 o_board_valid,
    output logic                 o_moved,
    output logic                 o_busy
);

    state_t              r_state, w_state_d;
    logic [BOARD_W-1:0]  r_work, w_work_d;
    logic [BOARD_W-1:0]  r_board;
    logic [1:0]          r_k, w_k_d;
    logic [1:0]          r_dir, w_dir_d;
    logic                r_changed, w_changed_d;
    logic                r_two, w_two_d;
    logic [3:0]          r_probe, w_probe_d;
    logic [3:0]          r_nprobe, w_nprobe_d;
    logic [15:0]         r_lfsr;
    logic                r_valid, r_moved;
    logic                w_commit, w_moved, w_found;
    logic [3:0]          w_tile;
    logic [3:0]          w_idx [4];
    logic [15:0]         w_line_in, w_line_out;
    logic                w_line_changed;
`ifdef GAME_2048_SCORE_EN
    logic [16:0]         w_line_score;
    logic [31:0]         r_pend, w_pend_d;
    logic [31:0]         r_score;
    logic                w_clr_score;
`endif

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_idx[j]            = cell_idx(r_dir, r_k, 2'(j));
            w_line_in[j*4 +: 4] = r_work[{w_idx[j], 2'b00} +: 4];
        end
    end

    game_2048_line_merge u_line_merge (
        .i_line    (w_line_in),
        .o_line    (w_line_out),
`ifdef GAME_2048_SCORE_EN
        .o_score   (w_line_score),
`endif
        .o_changed (w_line_changed)
    );

    assign w_tile = (r_lfsr[7:4] == FOUR_ODDS) ? 4'd2 : 4'd1;

    always_comb begin
        w_state_d   = r_state;
        w_work_d    = r_work;
        w_k_d       = r_k;
        w_dir_d     = r_dir;
        w_changed_d = r_changed;
        w_two_d     = r_two;
        w_probe_d   = r_probe;
        w_nprobe_d  = r_nprobe;
        w_commit    = 1'b0;
        w_moved     = 1'b0;
        w_found     = 1'b0;
`ifdef GAME_2048_SCORE_EN
        w_pend_d    = r_pend;
        w_clr_score = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (i_move_valid && !i_lock) begin
                    w_state_d   = StMove;
                    w_dir_d     = i_move_dir;
                    w_k_d       = 2'd0;
                    w_changed_d = 1'b0;
`ifdef GAME_2048_SCORE_EN
                    w_pend_d    = '0;
`endif
                end
            end
            StMove: begin
                for (int j = 0; j < 4; j++) begin
                    w_work_d[{w_idx[j], 2'b00} +: 4] = w_line_out[j*4 +: 4];
                end
                w_changed_d = r_changed | w_line_changed;
                w_k_d       = r_k + 2'd1;
`ifdef GAME_2048_SCORE_EN
                w_pend_d    = r_pend + 32'(w_line_score);
`endif
                if (r_k == 2'd3) begin
                    if (w_changed_d) begin
                        w_state_d  = StSpawn;
                        w_probe_d  = r_lfsr[3:0];
                        w_nprobe_d = '0;
                        w_two_d    = 1'b0;
                    end else begin
                        w_state_d = StDone;
                        w_commit  = 1'b1;
                    end
                end
            end
            StSpawn: begin
                if (r_work[{r_probe, 2'b00} +: 4] == TILE_EMPTY) begin
                    w_work_d[{r_probe, 2'b00} +: 4] = w_tile;
                    w_found = 1'b1;
                end
                // A full board after 16 probes ends this spawn without placing a tile.
                if (w_found || r_nprobe == 4'd15) begin
                    if (r_two) begin
                        w_two_d    = 1'b0;
                        w_probe_d  = r_lfsr[3:0];
                        w_nprobe_d = '0;
                    end else begin
                        w_state_d = StDone;
                        w_commit  = 1'b1;
                        w_moved   = 1'b1;
                    end
                end else begin
                    w_probe_d  = r_probe + 4'd1;
                    w_nprobe_d = r_nprobe + 4'd1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (i_load_valid) begin
            w_work_d  = i_load_board;
            w_state_d = StDone;
            w_commit  = 1'b1;
            w_moved   = 1'b1;
`ifdef GAME_2048_SCORE_EN
            w_pend_d  = '0;
`endif
        end
        if (i_new_game) begin
            w_work_d   = '0;
            w_state_d  = StSpawn;
            w_two_d    = 1'b1;
            w_probe_d  = r_lfsr[3:0];
            w_nprobe_d = '0;
            w_commit   = 1'b0;
            w_moved    = 1'b0;
`ifdef GAME_2048_SCORE_EN
            w_pend_d    = '0;
            w_clr_score = 1'b1;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_work    <= '0;
            r_board   <= '0;
            r_k       <= '0;
            r_dir     <= '0;
            r_changed <= 1'b0;
            r_two     <= 1'b0;
            r_probe   <= '0;
            r_nprobe  <= '0;
            r_lfsr    <= LFSR_SEED;
            r_valid   <= 1'b0;
            r_moved   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_work    <= w_work_d;
            r_k       <= w_k_d;
            r_dir     <= w_dir_d;
            r_changed <= w_changed_d;
            r_two     <= w_two_d;
            r_probe   <= w_probe_d;
            r_nprobe  <= w_nprobe_d;
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_valid   <= w_commit;
            if (w_commit) begin
                r_board <= w_work_d;
                r_moved <= w_moved;
            end
        end
    end

`ifdef GAME_2048_SCORE_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend  <= '0;
            r_score <= '0;
        end else begin
            r_pend <= w_pend_d;
            if (w_clr_score) begin
                r_score <= '0;
            end else if (w_commit) begin
                r_score <= r_score + w_pend_d;
            end
        end
    end

    assign o_score = r_score;
`endif

    assign o_move_ready  = (r_state == StIdle) && !i_lock;
    assign o_board_state = r_board;
    assign o_board_valid = r_valid;
    assign o_moved       = r_moved;
    assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_game_2048_move_engine.sv
// Randomized self-checking bench for game_2048_move_engine against a queue-based line model.
// Define GAME_2048_SCORE_EN to also check the score output.
module tb_game_2048_move_engine;
    import game_2048_pkg::*;

    logic        clk = 1'b0;
    logic        reset, move_valid, lock, new_game, load_valid;
    logic [1:0]  move_dir;
    logic [63:0] load_board;
    logic        move_ready, board_valid, moved, busy;
    logic [63:0] board_state;
`ifdef GAME_2048_SCORE_EN
    logic [31:0] score;
`endif
    logic [31:0] exp_score;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    game_2048_move_engine dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_move_valid  (move_valid),
        .i_move_dir    (move_dir),
        .o_move_ready  (move_ready),
        .i_lock        (lock),
        .i_new_game    (new_game),
        .i_load_valid  (load_valid),
        .i_load_board  (load_board),
        .o_board_state (board_state),
`ifdef GAME_2048_SCORE_EN
        .o_score       (score),
`endif
        .o_board_valid (board_valid),
        .o_moved       (moved),
        .o_busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_score(input string tag);
`ifdef GAME_2048_SCORE_EN
        check(tag, 64'(score), 64'(exp_score));
`endif
    endtask

    // Reference: gather nonzero tiles of each line, pair equal neighbours from the wall outward.
    function automatic logic [63:0] model_move(input logic [63:0] b, input logic [1:0] dir,
                                               output logic [31:0] sc);
        int g[16];
        logic [63:0] r;
        sc = 0;
        for (int i = 0; i < 16; i++) g[i] = int'(b[i*4 +: 4]);
        for (int k = 0; k < 4; k++) begin
            int idx[4];
            int q[$];
            int res[$];
            for (int j = 0; j < 4; j++) begin
                case (dir)
                    2'd0:    idx[j] = j * 4 + k;
                    2'd1:    idx[j] = (3 - j) * 4 + k;
                    2'd2:    idx[j] = k * 4 + j;
                    default: idx[j] = k * 4 + (3 - j);
                endcase
                if (g[idx[j]] != 0) q.push_back(g[idx[j]]);
            end
            while (q.size() > 0) begin
                if (q.size() >= 2 && q[0] == q[1] && q[0] != 15) begin
                    res.push_back(q[0] + 1);
                    sc = sc + (32'd1 << (q[0] + 1));
                    void'(q.pop_front());
                    void'(q.pop_front());
                end else begin
                    res.push_back(q.pop_front());
                end
            end
            while (res.size() < 4) res.push_back(0);
            for (int j = 0; j < 4; j++) g[idx[j]] = res[j];
        end
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(g[i]);
        return r;
    endfunction

    function automatic int count_nonzero(input logic [63:0] b);
        int n = 0;
        for (int i = 0; i < 16; i++) if (b[i*4 +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic bit small_tiles(input logic [63:0] b);
        bit ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (b[i*4 +: 4] > 4'd2) ok = 1'b0;
        return ok;
    endfunction

    // Exactly one cell differs: empty in the model, 1 or 2 in the DUT.
    function automatic bit spawn_ok(input logic [63:0] exp, input logic [63:0] got);
        int diffs = 0;
        bit ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (exp[i*4 +: 4] != got[i*4 +: 4]) begin
                diffs++;
                if (exp[i*4 +: 4] != 4'd0 || !(got[i*4 +: 4] inside {4'd1, 4'd2})) ok = 1'b0;
            end
        end
        return ok && diffs == 1;
    endfunction

    task automatic wait_valid(input string tag, input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            tick();
            move_valid = 1'b0;
            new_game   = 1'b0;
            load_valid = 1'b0;
            if (board_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_load(input logic [63:0] b);
        load_board = b;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("load_valid", 64'(board_valid), 64'd1);
        check("load_board", board_state, b);
        check_score("load_score");
        tick();
    endtask

    task automatic run_move(input string tag, input logic [63:0] b, input logic [1:0] dir);
        logic [63:0] exp;
        logic [31:0] sc;
        int          lat;
        bit          chg;
        do_load(b);
        exp = model_move(b, dir, sc);
        chg = (exp != b);
        check({tag, "_ready"}, 64'(move_ready), 64'd1);
        move_dir   = dir;
        move_valid = 1'b1;
        wait_valid(tag, 40, lat);
        check({tag, "_moved"}, 64'(moved), 64'(chg));
        if (chg) begin
            check({tag, "_spawn"}, 64'(spawn_ok(exp, board_state)), 64'd1);
            check({tag, "_lat"}, 64'(lat >= 6 && lat <= 21), 64'd1);
        end else begin
            check({tag, "_board"}, board_state, exp);
            check({tag, "_lat"}, 64'(lat), 64'd5);
        end
        exp_score = exp_score + sc;
        check_score({tag, "_score"});
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          seen;
        int          vals[6];
        logic [63:0] rb;
        vals = '{0, 0, 1, 2, 3, 15};
        reset = 1'b1; move_valid = 1'b0; lock = 1'b0; new_game = 1'b0;
        load_valid = 1'b0; move_dir = 2'd0; load_board = '0; exp_score = 0;
        tick();
        tick();
        check("rst_board", board_state, 64'd0);
        check("rst_valid", 64'(board_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_score("rst_score");
        reset = 1'b0;
        tick();
        check("rst_ready", 64'(move_ready), 64'd1);

        run_move("left_2211", 64'h0000_0000_0000_2211, DIR_LEFT);
        run_move("right_1111", 64'h0000_0000_0000_1111, DIR_RIGHT);
        run_move("up_checker", 64'h1212_2121_1212_2121, DIR_UP);
        run_move("left_max", 64'h0000_0000_0000_FF11, DIR_LEFT);
        run_move("down_112", 64'h0000_0002_0001_0001, DIR_DOWN);

        // new_game from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_score = 0;
        new_game = 1'b1;
        wait_valid("newgame", 40, lat);
        check("newgame_count", 64'(count_nonzero(board_state)), 64'd2);
        check("newgame_tiles", 64'(small_tiles(board_state)), 64'd1);
        check("newgame_moved", 64'(moved), 64'd1);
        check_score("newgame_score");
        tick();

        // lock blocks moves but not new_game
        lock = 1'b1;
        tick();
        check("lock_ready", 64'(move_ready), 64'd0);
        seen = 1'b0;
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (board_valid || busy) seen = 1'b1;
        end
        move_valid = 1'b0;
        check("lock_no_move", 64'(seen), 64'd0);
        new_game = 1'b1;
        wait_valid("lock_newgame", 40, lat);
        check("lock_newgame_count", 64'(count_nonzero(board_state)), 64'd2);
        lock = 1'b0;
        tick();

        // new_game two cycles after a move is accepted aborts the move
        do_load(64'h0000_0000_0000_2211);
        move_dir   = DIR_LEFT;
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        tick();
        new_game = 1'b1;
        wait_valid("abort", 40, lat);
        exp_score = 0;
        check("abort_count", 64'(count_nonzero(board_state)), 64'd2);
        check("abort_tiles", 64'(small_tiles(board_state)), 64'd1);
        check_score("abort_score");
        tick();

        // reset in the middle of SPAWN
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_board", board_state, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(board_valid), 64'd0);
        check_score("midrst_score");
        reset = 1'b0;
        tick();

        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 16; i++) rb[i*4 +: 4] = 4'(vals[$urandom_range(5, 0)]);
            run_move($sformatf("rnd%0d", it), rb, 2'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
